// File: rtl/pc_conf_pkg.sv
// Shared types and elaboration helpers for the PCParser config-channel deserializer array.
package pc_conf_pkg;

  typedef enum logic {
    ST_COLLECT,
    ST_FULL
  } chan_state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned chunks_of(input int unsigned width, input int unsigned nconf);
    return ceil_div(width, nconf);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

  // SpikeGenerator program word: generator select + two period fields + tag.
  localparam int unsigned SG_GENS_W   = 16;
  localparam int unsigned SG_PERIOD_W = 16;
  localparam int unsigned SG_TAG_W    = 3;
  localparam int unsigned SG_PROG_W   = SG_GENS_W + 2 * SG_PERIOD_W + SG_TAG_W;

  localparam int unsigned NCONF_DEFAULT    = 16;
  localparam int unsigned NOUT_MAX_DEFAULT = 64;

  localparam logic [3:0][15:0] DEFAULT_OUT_WIDTHS = {4{16'(SG_PROG_W)}};

  localparam int unsigned CHUNK_CNT_W = cnt_width(chunks_of(NOUT_MAX_DEFAULT, NCONF_DEFAULT));

endpackage

// File: rtl/pc_conf_deserializer_array_chan.sv
// One used channel: collects K chunks LSB-first into a W-bit word, then holds it until drained.
module pc_chan_deserializer
  import pc_conf_pkg::*;
#(
  parameter int unsigned Nconf    = 16,
  parameter int unsigned W        = 51,
  parameter int unsigned Nout_max = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Nconf-1:0]    in_d,
  input  logic                in_v,
  output logic                in_a,
  input  logic                flush,
  output logic [Nout_max-1:0] out_d,
  output logic                out_v,
  input  logic                out_a,
  output logic                busy
);

  localparam int unsigned K  = chunks_of(W, Nconf);
  localparam int unsigned CW = cnt_width(K);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          busy_q, busy_d;
  logic          take;
  logic          last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_v   = (state_q == ST_FULL);
    in_a    = !reset && !flush && ((state_q == ST_COLLECT) || out_a);
    take    = in_v && in_a;
    last    = (cnt_q == CW'(K - 1));

    if (flush) begin
      state_d = ST_COLLECT;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if ((state_q == ST_FULL) && out_a) state_d = ST_COLLECT;
      // In FULL cnt is 0, so a chunk taken while draining starts the next word.
      if (take) begin
        for (int unsigned b = 0; b < W; b++) begin
          if ((b / Nconf) == 32'(cnt_q)) acc_d[b] = in_d[b % Nconf];
        end
        if (last) begin
          state_d = ST_FULL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
    end
  end

  assign out_d = Nout_max'(acc_q);
  assign busy  = busy_q;

endmodule

// File: rtl/pc_conf_deserializer_array.sv
// Array of independent chunk-to-word deserializers; zero-width channels become input sinks.
module pc_conf_deserializer_array
  import pc_conf_pkg::*;
#(
  parameter int unsigned Nconf    = 16,
  parameter int unsigned Nchan    = 4,
  parameter int unsigned Nout_max = 64,
  parameter logic [Nchan-1:0][15:0] OUT_WIDTHS = DEFAULT_OUT_WIDTHS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [Nchan-1:0][Nconf-1:0]     in_d,
  input  logic [Nchan-1:0]                in_v,
  output logic [Nchan-1:0]                in_a,
  input  logic [Nchan-1:0]                flush,
  output logic [Nchan-1:0][Nout_max-1:0]  out_d,
  output logic [Nchan-1:0]                out_v,
  input  logic [Nchan-1:0]                out_a,
  output logic [Nchan-1:0]                busy
);

  for (genvar i = 0; i < Nchan; i++) begin : g_chan
    localparam int unsigned W = OUT_WIDTHS[i];

    if (W > Nout_max) begin : g_bad_width
      $error("pc_conf_deserializer_array: OUT_WIDTHS[%0d]=%0d exceeds Nout_max=%0d", i, W, Nout_max);
    end

    if (W == 0) begin : g_sink
      logic unused_ch;
      assign unused_ch = ^{in_d[i], flush[i], out_a[i]};
      assign in_a[i]   = in_v[i];
      assign out_v[i]  = 1'b0;
      assign out_d[i]  = '0;
      assign busy[i]   = 1'b0;
    end else begin : g_used
      pc_chan_deserializer #(
        .Nconf   (Nconf),
        .W       (W),
        .Nout_max(Nout_max)
      ) u_chan (
        .clk  (clk),
        .reset(reset),
        .in_d (in_d[i]),
        .in_v (in_v[i]),
        .in_a (in_a[i]),
        .flush(flush[i]),
        .out_d(out_d[i]),
        .out_v(out_v[i]),
        .out_a(out_a[i]),
        .busy (busy[i])
      );
    end
  end

endmodule

// File: tb/tb_pc_conf_deserializer_array.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random scoreboard.
module tb_pc_conf_deserializer_array;

  localparam logic [3:0][15:0] OW = {16'd0, 16'd51, 16'd51, 16'd51};

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0][15:0]      in_d;
  logic [3:0]            in_v, in_a, flush, out_v, out_a, busy;
  logic [3:0][63:0]      out_d;

  int checks = 0;
  int errors = 0;

  pc_conf_deserializer_array #(
    .Nconf     (16),
    .Nchan     (4),
    .Nout_max  (64),
    .OUT_WIDTHS(OW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in_d (in_d),
    .in_v (in_v),
    .in_a (in_a),
    .flush(flush),
    .out_d(out_d),
    .out_v(out_v),
    .out_a(out_a),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    in_v  = '0;
    flush = '0;
    out_a = '1;
  endtask

  // ---------------- reference model: chunk lists per channel ----------------
  int          m_cnt  [4];
  bit          m_full [4];
  logic [63:0] m_held [4];
  logic [15:0] m_parts[4][4];

  function automatic int width_of(input int ch);
    logic [15:0] w;
    w = OW[ch];
    return int'(w);
  endfunction

  function automatic int k_of(input int ch);
    return (width_of(ch) + 15) / 16;
  endfunction

  function automatic logic [63:0] assemble(input int ch);
    logic [63:0] word;
    word = '0;
    for (int j = 0; j < k_of(ch); j++) word |= 64'(m_parts[ch][j]) << (16 * j);
    if (width_of(ch) < 64) word &= (64'd1 << width_of(ch)) - 64'd1;
    return word;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_cnt[ch]  = 0;
      m_full[ch] = 0;
      m_held[ch] = '0;
    end
  endtask

  // Called between edges after inputs are applied: checks outputs, then advances model.
  task automatic model_cycle();
    for (int ch = 0; ch < 4; ch++) begin
      bit exp_ia, in_x, out_x;
      if (width_of(ch) == 0) begin
        chk($sformatf("rnd_sink_in_a%0d", ch), 64'(in_a[ch]), 64'(in_v[ch]));
        chk($sformatf("rnd_sink_out_v%0d", ch), 64'(out_v[ch]), 64'd0);
        chk($sformatf("rnd_sink_out_d%0d", ch), out_d[ch], 64'd0);
        chk($sformatf("rnd_sink_busy%0d", ch), 64'(busy[ch]), 64'd0);
      end else begin
        exp_ia = !flush[ch] && (!m_full[ch] || out_a[ch]);
        chk($sformatf("rnd_in_a%0d", ch), 64'(in_a[ch]), 64'(exp_ia));
        chk($sformatf("rnd_out_v%0d", ch), 64'(out_v[ch]), 64'(m_full[ch]));
        chk($sformatf("rnd_busy%0d", ch), 64'(busy[ch]), 64'(m_cnt[ch] != 0));
        chk($sformatf("rnd_hi_zero%0d", ch), out_d[ch] >> width_of(ch), 64'd0);
        if (m_full[ch]) chk($sformatf("rnd_out_d%0d", ch), out_d[ch], m_held[ch]);
        out_x = m_full[ch] && out_a[ch];
        in_x  = in_v[ch] && exp_ia;
        if (flush[ch]) begin
          m_cnt[ch]  = 0;
          m_full[ch] = 0;
        end else begin
          if (out_x) m_full[ch] = 0;
          if (in_x) begin
            m_parts[ch][m_cnt[ch]] = in_d[ch];
            m_cnt[ch]++;
            if (m_cnt[ch] == k_of(ch)) begin
              m_held[ch] = assemble(ch);
              m_full[ch] = 1;
              m_cnt[ch]  = 0;
            end
          end
        end
      end
    end
  endtask

  // ---------------- directed vector table for channel 0 ----------------
  typedef struct {
    logic [15:0] d;
    logic        v;
    logic        oa;
    logic        fl;
    logic        e_ia;
    logic        e_ov;
    logic [63:0] e_od;
    logic        e_busy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic [15:0] d, input logic v, input logic oa, input logic fl,
                              input logic e_ia, input logic e_ov, input logic [63:0] e_od,
                              input logic e_busy);
    vec_t r;
    r.d = d; r.v = v; r.oa = oa; r.fl = fl;
    r.e_ia = e_ia; r.e_ov = e_ov; r.e_od = e_od; r.e_busy = e_busy;
    return r;
  endfunction

  localparam logic [63:0] WORD_A = 64'h0007_0003_0002_0001;
  localparam logic [63:0] WORD_B = 64'h0005_000C_000B_000A;

  initial begin
    logic [15:0] fresh[4];
    logic [15:0] rchunks[4];

    tbl[0]  = mk(16'h0001, 1, 1, 0, 1, 0, 64'd0,  0);
    tbl[1]  = mk(16'h0002, 1, 1, 0, 1, 0, 64'd0,  1);
    tbl[2]  = mk(16'h0003, 1, 1, 0, 1, 0, 64'd0,  1);
    tbl[3]  = mk(16'hFFFF, 1, 1, 0, 1, 0, 64'd0,  1);
    tbl[4]  = mk(16'h0000, 0, 1, 0, 1, 1, WORD_A, 0);
    tbl[5]  = mk(16'h000A, 1, 0, 0, 1, 0, 64'd0,  0);
    tbl[6]  = mk(16'h000B, 1, 0, 0, 1, 0, 64'd0,  1);
    tbl[7]  = mk(16'h000C, 1, 0, 0, 1, 0, 64'd0,  1);
    tbl[8]  = mk(16'h000D, 1, 0, 0, 1, 0, 64'd0,  1);
    tbl[9]  = mk(16'h1234, 1, 0, 0, 0, 1, WORD_B, 0);
    tbl[10] = mk(16'h1234, 1, 0, 0, 0, 1, WORD_B, 0);
    tbl[11] = mk(16'h1234, 1, 1, 0, 1, 1, WORD_B, 0);
    tbl[12] = mk(16'h0000, 0, 1, 0, 1, 0, 64'd0,  1);

    // ---- reset state ----
    reset = 1'b1;
    in_d  = '0;
    idle();
    in_v  = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_a", 64'(in_a), 64'h8);
    chk("reset_out_v", 64'(out_v), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("reset_out_d%0d", ch), out_d[ch], 64'd0);
    in_v = '0;
    @(negedge clk);
    reset = 1'b0;

    // ---- ch0 word assembly and backpressure ----
    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      in_d[0]  = tbl[r].d;
      in_v[0]  = tbl[r].v;
      out_a[0] = tbl[r].oa;
      flush[0] = tbl[r].fl;
      #1;
      chk($sformatf("tbl%0d_in_a", r), 64'(in_a[0]), 64'(tbl[r].e_ia));
      chk($sformatf("tbl%0d_out_v", r), 64'(out_v[0]), 64'(tbl[r].e_ov));
      chk($sformatf("tbl%0d_busy", r), 64'(busy[0]), 64'(tbl[r].e_busy));
      if (tbl[r].e_ov) chk($sformatf("tbl%0d_out_d", r), out_d[0], tbl[r].e_od);
    end

    // ---- flush mid-word on ch1 ----
    @(negedge clk);
    idle();
    in_v[1] = 1; in_d[1] = 16'h1111;
    #1 chk("fl_in_a0", 64'(in_a[1]), 64'd1);
    @(negedge clk);
    in_d[1] = 16'h2222;
    #1 chk("fl_busy_pre", 64'(busy[1]), 64'd1);
    @(negedge clk);
    in_d[1] = 16'h3333; flush[1] = 1;
    #1 chk("fl_in_a_low", 64'(in_a[1]), 64'd0);
    @(negedge clk);
    flush[1] = 0; in_v[1] = 0;
    #1 chk("fl_busy_post", 64'(busy[1]), 64'd0);
    chk("fl_out_v_post", 64'(out_v[1]), 64'd0);
    fresh = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_v[1] = 1; in_d[1] = fresh[j];
    end
    @(negedge clk);
    in_v[1] = 0;
    #1 chk("fl_word_v", 64'(out_v[1]), 64'd1);
    chk("fl_word_d", out_d[1], 64'h0005_CCCC_BBBB_AAAA);

    // ---- unused channel 3 ----
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_v[3]  = 1'($urandom_range(0, 1));
      in_d[3]  = 16'($urandom);
      flush[3] = 1'($urandom_range(0, 1));
      out_a[3] = 1'($urandom_range(0, 1));
      #1;
      chk("sink_in_a", 64'(in_a[3]), 64'(in_v[3]));
      chk("sink_out_v", 64'(out_v[3]), 64'd0);
      chk("sink_busy", 64'(busy[3]), 64'd0);
    end

    // ---- async reset mid-word on ch2 ----
    @(negedge clk);
    idle();
    rchunks = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_v[2] = 1; in_d[2] = rchunks[j];
    end
    @(negedge clk);
    in_d[2] = rchunks[3];
    #1 chk("ar_busy_pre", 64'(busy[2]), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_busy", 64'(busy[2]), 64'd0);
    chk("ar_out_v", 64'(out_v[2]), 64'd0);
    chk("ar_in_a", 64'(in_a[2]), 64'd0);
    chk("ar_out_d", out_d[2], 64'd0);
    @(negedge clk);
    reset = 1'b0; in_v[2] = 0;
    rchunks = '{16'h1000, 16'h2000, 16'h3000, 16'h4FFF};
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_v[2] = 1; in_d[2] = rchunks[j];
      #1 chk($sformatf("ar_acc_in_a%0d", j), 64'(in_a[2]), 64'd1);
    end
    @(negedge clk);
    in_v[2] = 0;
    #1 chk("ar_word_v", 64'(out_v[2]), 64'd1);
    chk("ar_word_d", out_d[2], 64'h0007_3000_2000_1000);

    // ---- random streaming on all channels against the model ----
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        in_d[ch]  = 16'($urandom);
        in_v[ch]  = ($urandom_range(0, 3) != 0);
        out_a[ch] = (c >= 450) ? 1'b1 : ($urandom_range(0, 2) != 0);
        flush[ch] = (c < 450) && ($urandom_range(0, 31) == 0);
      end
      #1 model_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
